// File: rtl/clk_mon_mc_pkg.sv
// Shared types and constants for the multi-channel clock monitor.
package clk_mon_mc_pkg;

    typedef enum logic {
        ChOk   = 1'b0,
        ChFail = 1'b1
    } ch_state_e;

    localparam int unsigned MaxCh = 16;

    function automatic int unsigned win_cnt_w(input int unsigned win_len);
        return (win_len > 1) ? $clog2(win_len) : 1;
    endfunction

endpackage

// File: rtl/clk_mon_chan.sv
// One monitored channel: synchroniser, rising-edge counter, OK/FAIL hysteresis FSM
// and sticky error bit. Window boundaries come from the shared counter in the top.
module clk_mon_chan
    import clk_mon_mc_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MIN_EDGES = 7,
    parameter int unsigned MAX_EDGES = 255,
    parameter int unsigned HYST      = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mon_i,
    input  logic             win_end_i,
    input  logic             err_clr_i,
    output logic             err_o,
    output logic             err_sticky_o,
    output logic [CNT_W-1:0] meas_o
);

    logic [1:0]       sync_q;
    logic             hist_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] meas_q;
    logic [CNT_W-1:0] total;
    logic [3:0]       gcnt_q;
    ch_state_e        state_q;
    logic             sticky_q;
    logic             rise;
    logic             win_good;
    logic             fail_next;

    // Total includes an edge seen on the closing cycle; saturates instead of wrapping.
    always_comb begin
        rise      = sync_q[1] & ~hist_q;
        total     = cnt_q + CNT_W'(rise && !(&cnt_q));
        win_good  = (32'(total) >= MIN_EDGES) && (32'(total) <= MAX_EDGES);
        fail_next = (state_q == ChOk) ? !win_good
                                      : !(win_good && (gcnt_q == 4'(HYST - 1)));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            cnt_q    <= '0;
            meas_q   <= '0;
            gcnt_q   <= '0;
            state_q  <= ChOk;
            sticky_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], mon_i};
            hist_q <= sync_q[1];
            if (win_end_i) begin
                cnt_q  <= '0;
                meas_q <= total;
                unique case (state_q)
                    ChOk: begin
                        if (!win_good) begin
                            state_q <= ChFail;
                        end
                    end
                    ChFail: begin
                        if (!win_good) begin
                            gcnt_q <= '0;
                        end else if (gcnt_q == 4'(HYST - 1)) begin
                            state_q <= ChOk;
                            gcnt_q  <= '0;
                        end else begin
                            gcnt_q <= gcnt_q + 4'd1;
                        end
                    end
                    default: state_q <= ChOk;
                endcase
            end else begin
                cnt_q <= total;
            end
            // Set beats clear when both land on the same cycle.
            if (win_end_i && fail_next) begin
                sticky_q <= 1'b1;
            end else if (err_clr_i) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign err_o        = (state_q == ChFail);
    assign err_sticky_o = sticky_q;
    assign meas_o       = meas_q;

endmodule

// File: rtl/clk_mon_mc.sv
// Multi-channel clock monitor: counts rising edges per channel over a shared fixed
// window and flags channels whose count falls outside [MIN_EDGES, MAX_EDGES].
module clk_mon_mc
    import clk_mon_mc_pkg::*;
#(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned WIN_LEN   = 128,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MIN_EDGES = 7,
    parameter int unsigned MAX_EDGES = 255,
    parameter int unsigned HYST      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       mon_in,
    input  logic                  err_clr,
    output logic [N_CH-1:0]       err,
    output logic [N_CH-1:0]       err_sticky,
    output logic [N_CH*CNT_W-1:0] meas,
    output logic                  win_done
);

    localparam int unsigned WinW   = win_cnt_w(WIN_LEN);
    // Channels beyond the supported maximum are not built.
    localparam int unsigned NChGen = (N_CH <= MaxCh) ? N_CH : MaxCh;

    logic [WinW-1:0] win_cnt_q;
    logic            win_end;
    logic            win_done_q;

    assign win_end = (win_cnt_q == WinW'(WIN_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            win_done_q <= 1'b0;
        end else begin
            win_cnt_q  <= win_end ? '0 : win_cnt_q + WinW'(1);
            win_done_q <= win_end;
        end
    end

    assign win_done = win_done_q;

    for (genvar k = 0; k < NChGen; k++) begin : g_chan
        clk_mon_chan #(
            .CNT_W    (CNT_W),
            .MIN_EDGES(MIN_EDGES),
            .MAX_EDGES(MAX_EDGES),
            .HYST     (HYST)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .mon_i       (mon_in[k]),
            .win_end_i   (win_end),
            .err_clr_i   (err_clr),
            .err_o       (err[k]),
            .err_sticky_o(err_sticky[k]),
            .meas_o      (meas[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_clk_mon_mc.sv
// Self-checking bench for clk_mon_mc: toggle-pattern stimulus against a window-level
// reference model; a second instance with 4-bit counters covers saturation.
module tb_clk_mon_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  mon_in;
    logic [1:0]  err, err_sticky, err4, sticky4;
    logic [15:0] meas;
    logic [7:0]  meas4;
    logic        win_done, win_done4;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    clk_mon_mc #(
        .N_CH(2), .WIN_LEN(128), .CNT_W(8), .MIN_EDGES(7), .MAX_EDGES(20), .HYST(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mon_in(mon_in), .err_clr(err_clr),
        .err(err), .err_sticky(err_sticky), .meas(meas), .win_done(win_done)
    );

    clk_mon_mc #(
        .N_CH(2), .WIN_LEN(128), .CNT_W(4), .MIN_EDGES(7), .MAX_EDGES(20), .HYST(2)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .mon_in(mon_in), .err_clr(err_clr),
        .err(err4), .err_sticky(sticky4), .meas(meas4), .win_done(win_done4)
    );

    // Stimulus: per-channel toggle every hp clocks, or hold a level when hp == 0.
    int unsigned hp[2] = '{0, 0};
    int unsigned ph[2] = '{0, 0};
    logic [1:0]  hold = 2'b00;

    initial begin
        mon_in = 2'b00;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                if (hp[ch] == 0) begin
                    mon_in[ch] = hold[ch];
                end else begin
                    ph[ch]++;
                    if (ph[ch] >= hp[ch]) begin
                        mon_in[ch] = ~mon_in[ch];
                        ph[ch] = 0;
                    end
                end
            end
        end
    end

    // Reference model: a rising edge of mon_in becomes countable two clocks after it
    // is first sampled; windows close every 128 clocks counted from reset release.
    int unsigned t_cyc;
    logic [1:0]  s1, s2, s3;
    int unsigned acc[2], acc4[2], m_meas[2], m_meas4[2], m_streak[2];
    logic [1:0]  m_fail, m_sticky;
    logic        m_wd;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t_cyc = 0; s1 = 0; s2 = 0; s3 = 0; m_fail = 0; m_sticky = 0; m_wd = 0;
                for (int ch = 0; ch < 2; ch++) begin
                    acc[ch] = 0; acc4[ch] = 0; m_meas[ch] = 0; m_meas4[ch] = 0;
                    m_streak[ch] = 0;
                end
            end else begin
                t_cyc++;
                m_wd = 1'b0;
                for (int ch = 0; ch < 2; ch++) begin
                    if (s2[ch] && !s3[ch]) begin
                        if (acc[ch] < 255) acc[ch]++;
                        if (acc4[ch] < 15) acc4[ch]++;
                    end
                end
                s3 = s2; s2 = s1; s1 = mon_in;
                for (int ch = 0; ch < 2; ch++) begin
                    logic set;
                    set = 1'b0;
                    if (t_cyc % 128 == 0) begin
                        logic good;
                        m_wd = 1'b1;
                        m_meas[ch] = acc[ch];
                        m_meas4[ch] = acc4[ch];
                        good = (acc[ch] >= 7) && (acc[ch] <= 20);
                        if (!m_fail[ch]) begin
                            m_fail[ch] = !good;
                        end else if (!good) begin
                            m_streak[ch] = 0;
                        end else begin
                            m_streak[ch]++;
                            if (m_streak[ch] == 2) begin
                                m_fail[ch] = 1'b0;
                                m_streak[ch] = 0;
                            end
                        end
                        set = m_fail[ch];
                        acc[ch] = 0;
                        acc4[ch] = 0;
                    end
                    if (set) m_sticky[ch] = 1'b1;
                    else if (err_clr) m_sticky[ch] = 1'b0;
                end
            end
        end
    end

    task automatic wait_win(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!win_done && cyc < 300);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({err, err_sticky, meas, win_done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_main: got %h expected 0", {err, err_sticky, meas, win_done});
        end
        n_cmp++;
        if ({err4, sticky4, meas4, win_done4} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_sat: got %h expected 0", {err4, sticky4, meas4, win_done4});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        int cyc;
        hp[0] = 8; hp[1] = 0; hold = 2'b00;
        wait_win(cyc);
        n_cmp++;
        if (!win_done || !m_wd) begin
            n_fail++;
            $display("FAIL nom_timing: win_done %b model %b after %0d clk", win_done, m_wd, cyc);
        end
        n_cmp++;
        if (meas[7:0] < 7 || meas[7:0] > 9 || meas[7:0] !== 8'(m_meas[0])) begin
            n_fail++;
            $display("FAIL nom_meas0: got %0d expected %0d (7..9)", meas[7:0], m_meas[0]);
        end
        n_cmp++;
        if (meas[15:8] !== 8'd0 || err !== 2'b10 || err_sticky !== 2'b10) begin
            n_fail++;
            $display("FAIL nom_ch1_dead: got meas1=%0d err=%b sticky=%b expected 0 10 10",
                     meas[15:8], err, err_sticky);
        end
    endtask

    task automatic test_recovery();
        int cyc;
        hp[1] = 8;
        wait_win(cyc);
        n_cmp++;
        if (err[1] !== 1'b1 || meas[15:8] !== 8'(m_meas[1]) || cyc > 128) begin
            n_fail++;
            $display("FAIL rec_first: got err1=%b meas1=%0d cyc=%0d expected 1 %0d <=128",
                     err[1], meas[15:8], cyc, m_meas[1]);
        end
        wait_win(cyc);
        n_cmp++;
        if (err[1] !== 1'b0 || err_sticky[1] !== 1'b1 || cyc != 128) begin
            n_fail++;
            $display("FAIL rec_second: got err1=%b sticky1=%b cyc=%0d expected 0 1 128",
                     err[1], err_sticky[1], cyc);
        end
    endtask

    task automatic test_fast();
        int cyc;
        hp[0] = 2;
        wait_win(cyc);
        n_cmp++;
        if (meas[7:0] !== 8'(m_meas[0]) || meas4[3:0] !== 4'(m_meas4[0])) begin
            n_fail++;
            $display("FAIL fast_mixed: got %0d/%0d expected %0d/%0d",
                     meas[7:0], meas4[3:0], m_meas[0], m_meas4[0]);
        end
        wait_win(cyc);
        n_cmp++;
        if (meas[7:0] !== 8'd32 || err[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_meas: got meas0=%0d err0=%b expected 32 1", meas[7:0], err[0]);
        end
        n_cmp++;
        if (meas4[3:0] !== 4'd15) begin
            n_fail++;
            $display("FAIL fast_saturate: got %0d expected 15", meas4[3:0]);
        end
    endtask

    task automatic test_err_clr();
        int guard;
        repeat (2) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++;
        if (err_sticky !== 2'b00 || err_sticky !== m_sticky) begin
            n_fail++;
            $display("FAIL clr_plain: got %b expected 00", err_sticky);
        end
        guard = 0;
        while (t_cyc % 128 != 127 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_cmp++;
        if (win_done !== 1'b1 || err_sticky !== 2'b01) begin
            n_fail++;
            $display("FAIL clr_vs_set: got win_done=%b sticky=%b expected 1 01",
                     win_done, err_sticky);
        end
    endtask

    task automatic test_random();
        int cyc;
        for (int w = 0; w < 8; w++) begin
            for (int ch = 0; ch < 2; ch++) begin
                int unsigned v;
                v = $urandom_range(0, 11);
                hp[ch] = (v == 0) ? 0 : v + 1;
                hold[ch] = 1'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 100)) @(negedge clk);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
            end
            wait_win(cyc);
            n_cmp++;
            if (!win_done || !m_wd || meas !== {8'(m_meas[1]), 8'(m_meas[0])} ||
                meas4 !== {4'(m_meas4[1]), 4'(m_meas4[0])} || err !== m_fail ||
                err_sticky !== m_sticky) begin
                n_fail++;
                $display("FAIL rand_win%0d: got wd=%b meas=%h m4=%h err=%b st=%b expected wd=1 meas=%h m4=%h err=%b st=%b",
                         w, win_done, meas, meas4, err, err_sticky,
                         {8'(m_meas[1]), 8'(m_meas[0])}, {4'(m_meas4[1]), 4'(m_meas4[0])},
                         m_fail, m_sticky);
            end
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        int guard;
        hp[0] = 8; hp[1] = 8;
        guard = 0;
        while (t_cyc % 128 != 60 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({err, err_sticky, meas, win_done} !== 21'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h expected 0", {err, err_sticky, meas, win_done});
        end
        rst_n = 1'b1;
        wait_win(cyc);
        n_cmp++;
        if (cyc != 128 || !win_done) begin
            n_fail++;
            $display("FAIL midrst_window: got %0d clk expected 128", cyc);
        end
        n_cmp++;
        if (meas !== {8'(m_meas[1]), 8'(m_meas[0])} || err !== m_fail) begin
            n_fail++;
            $display("FAIL midrst_meas: got meas=%h err=%b expected %h %b",
                     meas, err, {8'(m_meas[1]), 8'(m_meas[0])}, m_fail);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_nominal();
        test_recovery();
        test_fast();
        test_err_clr();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
